// File: rtl/alu_logic_serial.sv
// rtl/alu_logic_serial.sv - multi-cycle sliced bitwise logic unit (AND/OR/XOR/NOT/CH/MAJ)
//
// Purpose:
//   Bitwise logic unit for the SHA-256 datapath. A request is accepted in IDLE,
//   the operands and opcode are captured, and the result is built SLICE bits
//   per cycle (least significant slice first). The finished result is offered
//   with out_valid and held until the sink takes it.
//
// Ports:
//   clock          in   1      rising-edge clock
//   resetn         in   1      asynchronous active-low reset
//   in_valid       in   1      request valid
//   in_ready       out  1      request can be taken (IDLE only)
//   ctrl_op        in   3      000 AND, 001 OR, 010 XOR, 011 NOT A, 100 CH, 101 MAJ, 11x illegal
//   data_operandA  in   WIDTH  operand A
//   data_operandB  in   WIDTH  operand B
//   data_operandC  in   WIDTH  operand C (CH/MAJ only)
//   out_valid      out  1      result valid
//   out_ready      in   1      sink accepts the result
//   data_result    out  WIDTH  result, stable while out_valid
//   op_err         out  1      illegal opcode on the current result, qualified by out_valid

module alu_logic_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [WIDTH-1:0] data_operandC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             op_err
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_CH  = 3'b100;
    localparam logic [2:0] OP_MAJ = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic             accept;
    logic             last_slice;
    logic [WIDTH-1:0] func_word;

    // Only the IDLE handshake samples the input ports; everything after that
    // works from the captured copies, so input changes mid-op are harmless.
    assign accept     = (state_q == S_IDLE) && in_valid;
    assign last_slice = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A request presented here is not taken; it waits for IDLE.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        op_err      = 1'b0;
        data_result = result_q;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                op_err    = err_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Full-width logic function of the captured operands. Only the slice
    // selected by the counter is committed each RUN cycle. Illegal opcodes
    // produce zero so the result register ends up all-zero.
    // ------------------------------------------------------------------
    always_comb begin
        func_word = '0;
        case (op_q)
            OP_AND:  func_word = a_q & b_q;
            OP_OR:   func_word = a_q | b_q;
            OP_XOR:  func_word = a_q ^ b_q;
            OP_NOT:  func_word = ~a_q;
            OP_CH:   func_word = (a_q & b_q) ^ (~a_q & c_q);
            OP_MAJ:  func_word = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
            default: func_word = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        if (accept) begin
            a_d      = data_operandA;
            b_d      = data_operandB;
            c_d      = data_operandC;
            op_d     = ctrl_op;
            cnt_d    = '0;
            result_d = '0;
            err_d    = (ctrl_op[2:1] == 2'b11);
        end else if (state_q == S_RUN) begin
            // Counter parks at zero after the last slice instead of wrapping
            // through an out-of-range value.
            cnt_d = last_slice ? '0 : (cnt_q + CNT_ONE);
            // Constant-index slice write keeps the mux explicit per slice.
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    result_d[i*SLICE +: SLICE] = func_word[i*SLICE +: SLICE];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule
